pc_fetch_reg: RTL and testbench

//  Program-counter register and fetch sequencer directly downstream of the PC-select mux.

---
 rtl/pc_fetch_reg.sv | 163 ++++++++++++++++
 tb/tb_pc_fetch_reg.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_reg.sv
// Program-counter register and single-outstanding instruction fetch sequencer.
// Sits between pc_mux and decode; handles redirects, stale-response draining and a sticky misaligned-PC fault.

module pc_fetch_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_next,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        pc_fault
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_VALID = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  function automatic logic misaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [31:0] pc_r;
  logic [31:0] pc_s;
  logic [31:0] instr_r;
  logic [31:0] instr_s;
  logic        fault_r;
  logic        fault_s;
  logic        req_valid_r;
  logic        instr_valid_r;

  // Next-state, next-PC, captured instruction and fault decision
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    instr_s = instr_r;
    fault_s = fault_r;
    if (flush) begin
      // A redirect lands directly on flush_pc unless a response is still in flight
      pc_s    = flush_pc;
      fault_s = misaligned(flush_pc);
      state_s = misaligned(flush_pc) ? ST_HALT : ST_REQ;
      case (state_r)
        ST_REQ: begin
          if (imem_req_ready) begin
            state_s = ST_DRAIN;
            fault_s = 1'b0;
          end else begin
            state_s = misaligned(flush_pc) ? ST_HALT : ST_REQ;
          end
        end
        ST_WAIT, ST_DRAIN: begin
          if (!imem_rsp_valid) begin
            state_s = ST_DRAIN;
            fault_s = 1'b0;
          end else begin
            state_s = misaligned(flush_pc) ? ST_HALT : ST_REQ;
          end
        end
        default: begin
          state_s = misaligned(flush_pc) ? ST_HALT : ST_REQ;
        end
      endcase
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_REQ;
        end
        ST_REQ: begin
          if (imem_req_ready) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            instr_s = imem_rsp_data;
            state_s = ST_VALID;
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_DRAIN: begin
          // Stale response discarded; a misaligned redirect faults only now
          if (imem_rsp_valid) begin
            fault_s = misaligned(pc_r);
            state_s = misaligned(pc_r) ? ST_HALT : ST_REQ;
          end else begin
            state_s = ST_DRAIN;
          end
        end
        ST_VALID: begin
          if (instr_ready) begin
            pc_s    = pc_next;
            fault_s = misaligned(pc_next);
            state_s = misaligned(pc_next) ? ST_HALT : ST_REQ;
          end else begin
            state_s = ST_VALID;
          end
        end
        ST_HALT: begin
          state_s = ST_HALT;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, PC, instruction and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      pc_r          <= RESET_PC;
      instr_r       <= 32'd0;
      fault_r       <= 1'b0;
      req_valid_r   <= 1'b0;
      instr_valid_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      instr_r       <= instr_s;
      fault_r       <= fault_s;
      req_valid_r   <= (state_s == ST_REQ);
      instr_valid_r <= (state_s == ST_VALID);
    end
  end

  assign imem_req_valid = req_valid_r;
  assign imem_addr      = pc_r;
  assign instr_valid    = instr_valid_r;
  assign instr          = instr_r;
  assign instr_pc       = pc_r;
  assign pc_plus4       = pc_r + 32'd4;
  assign pc_fault       = fault_r;

  // Memory responses may only arrive while a request is outstanding
  a_rsp_in_window: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (state_r == ST_WAIT || state_r == ST_DRAIN));

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (req_valid_r && !imem_req_ready && !flush) |=> (req_valid_r && $stable(imem_addr)));

endmodule

// File: tb/tb_pc_fetch_reg.sv
// Directed plus randomized bench for pc_fetch_reg: the bench acts as instruction memory and decode.
// Expected PCs follow the architectural rules (next = pc_next / flush_pc, +4 wraps mod 2^32).

module tb_pc_fetch_reg;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_next;
  logic        flush;
  logic [31:0] flush_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        pc_fault;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pc_fetch_reg #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_next        (pc_next),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .pc_plus4       (pc_plus4),
    .pc_fault       (pc_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete instruction: request, response, decode accept with pc_next = nxt
  task automatic fetch_one(input logic [31:0] exp_addr, input int rq_dly, input int rsp_dly,
                           input int acc_dly, input logic [31:0] data, input logic [31:0] nxt,
                           output int t_seen);
    int n;
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    t_seen = cyc;
    chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("req_addr", imem_addr, exp_addr);
    chk("instr_pc_req", instr_pc, exp_addr);
    chk("pc_plus4", pc_plus4, exp_addr + 32'd4);
    for (int i = 0; i < rq_dly; i++) begin
      tick();
      chk("req_hold", {30'd0, imem_req_valid, instr_valid}, 32'd2);
      chk("req_addr_hold", imem_addr, exp_addr);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("no_dup_req", {30'd0, imem_req_valid, instr_valid}, 32'd0);
    for (int i = 0; i < rsp_dly; i++) begin
      tick();
      chk("wait_idle", {30'd0, imem_req_valid, instr_valid}, 32'd0);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    chk("instr_valid", {30'd0, imem_req_valid, instr_valid}, 32'd1);
    chk("instr", instr, data);
    chk("instr_pc", instr_pc, exp_addr);
    for (int i = 0; i < acc_dly; i++) begin
      tick();
      chk("instr_hold_v", {30'd0, imem_req_valid, instr_valid}, 32'd1);
      chk("instr_hold", instr, data);
      chk("instr_pc_hold", instr_pc, exp_addr);
    end
    pc_next     = nxt;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    pc_next     = $urandom;
    chk("post_accept_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("post_accept_addr", imem_addr, nxt);
    if (nxt[1:0] != 2'b00) begin
      chk("fault_set", {31'd0, pc_fault}, 32'd1);
      chk("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
    end else begin
      chk("fault_clear", {31'd0, pc_fault}, 32'd0);
      chk("next_req", {31'd0, imem_req_valid}, 32'd1);
    end
  endtask

  initial begin
    int t0, t1, t2, td;
    logic [31:0] exp_pc;
    logic [31:0] nxt;

    rst_n = 1'b0; flush = 1'b0; flush_pc = 32'd0; pc_next = 32'd0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0; instr_ready = 1'b0;
    repeat (3) tick();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_fault", {31'd0, pc_fault}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_plus4", pc_plus4, RST_PC + 32'd4);
    rst_n = 1'b1;
    chk("idle_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("first_req", {31'd0, imem_req_valid}, 32'd1);
    chk("first_addr", imem_addr, RST_PC);

    // Zero-wait throughput: one fetch every 3 cycles
    fetch_one(32'h100, 0, 0, 0, $urandom, 32'h104, t0);
    fetch_one(32'h104, 0, 0, 0, $urandom, 32'h108, t1);
    fetch_one(32'h108, 0, 0, 0, $urandom, 32'h10C, t2);
    chk("tput_1", t1 - t0, 32'd3);
    chk("tput_2", t2 - t1, 32'd3);

    // Back-pressure everywhere
    fetch_one(32'h10C, 3, 2, 4, $urandom, 32'h110, td);

    // Flush in WAIT; stale 0xDEAD must be discarded
    chk("fl_req", {31'd0, imem_req_valid}, 32'd1);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    flush = 1'b1; flush_pc = 32'h200;
    tick();
    flush = 1'b0;
    chk("drain_quiet", {30'd0, imem_req_valid, instr_valid}, 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_DEAD;
    tick();
    imem_rsp_valid = 1'b0;
    chk("stale_dropped", {31'd0, instr_valid}, 32'd0);
    chk("redir_req", {31'd0, imem_req_valid}, 32'd1);
    chk("redir_addr", imem_addr, 32'h200);

    // Misaligned pc_next faults and halts; flush recovers
    fetch_one(32'h200, 0, 1, 0, 32'h1234_5678, 32'h102, td);
    repeat (3) begin
      tick();
      chk("halt_stay", {29'd0, pc_fault, imem_req_valid, instr_valid}, 32'd4);
    end
    flush = 1'b1; flush_pc = 32'h300;
    tick();
    flush = 1'b0;
    chk("recover_fault", {31'd0, pc_fault}, 32'd0);
    chk("recover_req", {31'd0, imem_req_valid}, 32'd1);
    fetch_one(32'h300, 1, 0, 1, $urandom, 32'h304, td);

    // Flush in REQ without handshake withdraws the request
    flush = 1'b1; flush_pc = 32'h400;
    tick();
    flush = 1'b0;
    chk("withdraw_req", {31'd0, imem_req_valid}, 32'd1);
    chk("withdraw_addr", imem_addr, 32'h400);
    fetch_one(32'h400, 0, 0, 0, $urandom, 32'h404, td);

    // Flush with misaligned target beats a same-cycle accept
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_0001;
    tick();
    imem_rsp_valid = 1'b0;
    chk("valid_before_flush", {31'd0, instr_valid}, 32'd1);
    instr_ready = 1'b1; pc_next = 32'h500; flush = 1'b1; flush_pc = 32'h601;
    tick();
    instr_ready = 1'b0; flush = 1'b0;
    chk("flush_wins_addr", imem_addr, 32'h601);
    chk("flush_misalign", {29'd0, pc_fault, imem_req_valid, instr_valid}, 32'd4);

    // Wrap of pc_plus4 at the top of the address space
    flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    chk("wrap_plus4", pc_plus4, 32'd0);
    chk("wrap_fault", {31'd0, pc_fault}, 32'd0);
    exp_pc = 32'hFFFF_FFFC;
    fetch_one(exp_pc, 0, 0, 0, $urandom, exp_pc + 32'd4, td);
    exp_pc = exp_pc + 32'd4;

    // Randomized traffic: sequential or jump targets, random stalls
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        nxt = $urandom & 32'hFFFF_FFFC;
      end else begin
        nxt = exp_pc + 32'd4;
      end
      fetch_one(exp_pc, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom, nxt, td);
      exp_pc = nxt;
    end

    // Reset while WAIT; the late response must be ignored
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, imem_req_valid}, 32'd0);
    chk("async_rst_addr", imem_addr, RST_PC);
    chk("async_rst_instr", instr, 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBEEF_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rerst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rerst_instr", instr, 32'd0);
    fetch_one(RST_PC, 0, 0, 0, 32'h0BAD_F00D, RST_PC + 32'd4, td);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
